// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: status bit positions, occupancy states, entry layout.
// Optional feature macro used by the stage: ALU_STICKY_OVF_EN.
package alu_pkg;

  localparam int ALU_WIDTH  = 32;
  localparam int ALU_DEST_W = 5;

  localparam int ST_NEG      = 3;
  localparam int ST_ZERO     = 2;
  localparam int ST_CARRY    = 1;
  localparam int ST_OVERFLOW = 0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  typedef struct packed {
    logic [ALU_WIDTH-1:0]  result;
    logic [ALU_DEST_W-1:0] dest;
  } alu_entry_t;

endpackage

// File: rtl/alu_result_stage_if.sv
// Bundle of the result stage's upstream/downstream handshakes and flag-register access.
// master = producer/consumer environment, slave = the stage itself.
interface alu_result_stage_if #(
  parameter int WIDTH  = 32,
  parameter int DEST_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_result;
  logic [3:0]        in_status;
  logic              in_set_flags;
  logic [DEST_W-1:0] in_dest;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_result;
  logic [DEST_W-1:0] out_dest;
  logic [3:0]        flags;
  logic              flag_wr_en;
  logic [3:0]        flag_wr_data;

  modport master (
    output in_valid, in_result, in_status, in_set_flags, in_dest,
    output out_ready, flag_wr_en, flag_wr_data,
    input  in_ready, out_valid, out_result, out_dest, flags
  );

  modport slave (
    input  in_valid, in_result, in_status, in_set_flags, in_dest,
    input  out_ready, flag_wr_en, flag_wr_data,
    output in_ready, out_valid, out_result, out_dest, flags
  );
endinterface

// File: rtl/alu_skid_buf.sv
// Generic two-entry valid/ready skid buffer; in_ready and out_valid both come straight from flops
// so downstream back-pressure never reaches the upstream side combinationally.
module alu_skid_buf
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  occ_e         state_q, state_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] skid_q, skid_d;
  logic         inReady_q, outValid_q;
  logic         inAcc, outAcc;

  assign inAcc       = in_valid_i && inReady_q;
  assign outAcc      = outValid_q && out_ready_i;
  assign in_ready_o  = inReady_q;
  assign out_valid_o = outValid_q;
  assign out_data_o  = head_q;

  // Head always holds the oldest entry; the skid slot only fills while the head is stalled.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (inAcc) begin
          state_d = ONE;
          head_d  = in_data_i;
        end
      end
      ONE: begin
        if (inAcc && outAcc) begin
          head_d = in_data_i;
        end else if (inAcc) begin
          state_d = TWO;
          skid_d  = in_data_i;
        end else if (outAcc) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (outAcc) begin
          state_d = ONE;
          head_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Handshake flags are precomputed from the next state so they are true registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      head_q     <= '0;
      skid_q     <= '0;
      inReady_q  <= 1'b1;
      outValid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      inReady_q  <= (state_d != TWO);
      outValid_q <= (state_d != EMPTY);
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: skid-buffered result/tag path plus the architectural NZCV register.
// Define ALU_STICKY_OVF_EN to add the sticky_ovf output.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH  = ALU_WIDTH,
  parameter int DEST_W = ALU_DEST_W
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_result_stage_if.slave  bus
`ifdef ALU_STICKY_OVF_EN
  ,
  output logic               sticky_ovf
`endif
);

  localparam int EW = WIDTH + DEST_W;

  logic [EW-1:0] outData;
  logic [3:0]    flags_q, flags_d;
  logic          flagAcc;

  alu_skid_buf #(.W(EW)) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (bus.in_valid),
    .in_ready_o  (bus.in_ready),
    .in_data_i   ({bus.in_result, bus.in_dest}),
    .out_valid_o (bus.out_valid),
    .out_ready_i (bus.out_ready),
    .out_data_o  (outData)
  );

  assign bus.out_result = outData[EW-1:DEST_W];
  assign bus.out_dest   = outData[DEST_W-1:0];
  assign bus.flags      = flags_q;

  // Flags follow accepted status immediately, not the entry's drain; a direct write takes priority.
  assign flagAcc = bus.in_valid && bus.in_ready && bus.in_set_flags;

  always_comb begin
    flags_d = flags_q;
    if (bus.flag_wr_en) begin
      flags_d = bus.flag_wr_data;
    end else if (flagAcc) begin
      flags_d = bus.in_status;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 4'b0000;
    end else begin
      flags_q <= flags_d;
    end
  end

`ifdef ALU_STICKY_OVF_EN
  logic stickyOvf_q, stickyOvf_d;

  // Only an explicit write of V=0 clears the sticky bit, and it beats a same-cycle set.
  always_comb begin
    stickyOvf_d = stickyOvf_q;
    if (bus.flag_wr_en && !bus.flag_wr_data[ST_OVERFLOW]) begin
      stickyOvf_d = 1'b0;
    end else if (flagAcc && bus.in_status[ST_OVERFLOW]) begin
      stickyOvf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stickyOvf_q <= 1'b0;
    end else begin
      stickyOvf_q <= stickyOvf_d;
    end
  end

  assign sticky_ovf = stickyOvf_q;
`endif

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Registered output stage placed directly downstream of the ALU function units (shifters, adder, logic). It accepts one result word plus its 4-bit NZCV status per cycle over a valid/ready handshake and buffers up to two entries in a skid buffer, so back-pressure never forms a combinational path into the ALU. It also owns the architectural flag register, updated from accepted status when the operation requests it.

## Interface
- WIDTH, 32, datapath width of result words
- DEST_W, 5, width of the destination register tag carried with each result
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  upstream result valid
- in_ready  out  1  stage can accept; registered
- in_result  in  WIDTH  ALU result
- in_status  in  4  NZCV from the unit: [3] ST_NEG, [2] ST_ZERO, [1] ST_CARRY, [0] ST_OVERFLOW
- in_set_flags  in  1  this operation updates the flag register
- in_dest  in  DEST_W  destination tag
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts head
- out_result  out  WIDTH  head result
- out_dest  out  DEST_W  head tag
- flags  out  4  architectural NZCV flag register
- flag_wr_en  in  1  direct flag write, e.g. a move-to-status instruction
- flag_wr_data  in  4  value for the direct write

## Operation
- Input accept: in_valid && in_ready. Output accept: out_valid && out_ready.
- FSM over occupancy:
  - EMPTY: in_ready=1, out_valid=0. Accept → ONE.
  - ONE: in_ready=1, out_valid=1. Accept without drain → TWO. Drain without accept → EMPTY. Accept and drain together → ONE, new entry becomes head.
  - TWO: in_ready=0, out_valid=1. Drain → ONE, skid entry moves to head.
- Order is strictly FIFO. Entries are never dropped or duplicated.
- Flag register updates on input accept when in_set_flags=1: flags ← in_status, visible the next cycle. Flags do not wait for the entry to drain.
- flag_wr_en in the same cycle as a flag-setting accept: the direct write wins and the accepted status is discarded for flags. The entry itself is still buffered.
- The stage does no arithmetic. Result and tag pass bit-exact.

## Timing
- Reset (async, rst_n=0): state EMPTY, in_ready=1, out_valid=0, out_result=0, out_dest=0, flags=4'b0000.
- Latency from accept to out_valid: 1 cycle. Sustained throughput: 1 entry per cycle with out_ready held high.
- in_ready is a flop output. It is 0 exactly in state TWO and does not depend on out_ready in the same cycle.
- out_result and out_dest hold stable while out_valid && !out_ready.
- Reset asserted mid-operation discards all buffered entries immediately. No output handshake completes in that cycle.

## Configuration
- ALU_STICKY_OVF_EN defined:
  - Adds output sticky_ovf (1 bit), reset 0.
  - Set on any flag-setting accept with in_status[ST_OVERFLOW]=1.
  - Cleared only when flag_wr_en=1 with flag_wr_data[ST_OVERFLOW]=0.
  - A simultaneous set and clear resolves to clear.
- Undefined: port and register are absent. All other behaviour is identical.

## Structure
- Shared package alu_pkg holds:
  - bit indices ST_NEG=3, ST_ZERO=2, ST_CARRY=1, ST_OVERFLOW=0;
  - the occupancy state enum (EMPTY, ONE, TWO);
  - a packed entry typedef {result, dest}.
- One sub-module, alu_skid_buf: the generic two-entry valid/ready buffer, parameterised on entry width. The flag register and sticky logic stay in the top module.

## Test plan
- Reset, then one accept with result 32'h0000_00F0, dest 3, status 4'b0010, set_flags=1 → out_valid next cycle with 32'hF0/3; flags=4'b0010 one cycle after accept.
- Hold out_ready=0, offer three entries A, B, C → A and B accepted; in_ready=0 from the cycle after B; C stalls. Release out_ready → A, B, C drain in order with no bubble after C is accepted.
- out_ready=1, in_valid=1 for 8 cycles → 8 outputs on 8 consecutive cycles; in_ready never drops.
- Flag-setting accept with status 4'b1000 in the same cycle as flag_wr_en with 4'b0101 → flags=4'b0101; the entry still emerges.
- Assert rst_n=0 while in TWO → out_valid=0 and in_ready=1 without waiting for a clock edge; flags=0.
- With ALU_STICKY_OVF_EN defined: accept status 4'b0001 with set_flags, then status 4'b0000 → sticky_ovf stays 1 until flag_wr_en with 4'b0000.
